// File: rtl/vco_phase_gen.sv
// Clocked NCO replacement for the ring oscillator: accumulates fcw and emits the 16-phase ring pattern.
// Optional period counter (wrap_count port) is built only when VCO_PHASE_WRAP_CNT_EN is defined.
module vco_phase_gen #(
    parameter int ACC_BITS      = 16,
    parameter int FCW_BITS      = 16,
    parameter int WRAP_CNT_BITS = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [FCW_BITS-1:0]      fcw,
    input  logic                     load,
    input  logic [4:0]               load_phase,
    output logic [15:0]              phases,
    output logic [4:0]               phase_idx,
    output logic                     wrap
`ifdef VCO_PHASE_WRAP_CNT_EN
    ,
    output logic [WRAP_CNT_BITS-1:0] wrap_count
`endif
);

    if ((ACC_BITS < 5) || (ACC_BITS > 32) || (FCW_BITS < 1) || (FCW_BITS > ACC_BITS)
        || (WRAP_CNT_BITS < 1)) begin : g_param_check
        $error("vco_phase_gen: illegal parameter combination");
    end

    // Ring pattern for index k: top k bits inverted for k<=16, then the inversion recedes from the top.
    function automatic logic [15:0] ring_decode(input logic [4:0] k);
        logic [15:0] t;
        if (k <= 5'd16) begin
            t = ~(16'hFFFF >> k);
        end else begin
            t = 16'hFFFF >> (k - 5'd16);
        end
        return 16'h5555 ^ t;
    endfunction

    logic [ACC_BITS-1:0] r_acc;
    logic                r_wrap;
    logic [15:0]         r_phases;
    logic [ACC_BITS:0]   w_fcw_ext;
    logic [ACC_BITS:0]   w_sum;
    logic [ACC_BITS-1:0] w_load_acc;
    logic [ACC_BITS-1:0] w_acc_next;
    logic                w_wrap_next;

    // Zero-extended increment and load value, written so that FCW_BITS==ACC_BITS and ACC_BITS==5 both work.
    always_comb begin
        w_fcw_ext                      = '0;
        w_fcw_ext[FCW_BITS-1:0]        = fcw;
        w_load_acc                     = '0;
        w_load_acc[ACC_BITS-1 -: 5]    = load_phase;
    end

    assign w_sum = {1'b0, r_acc} + w_fcw_ext;

    // Next accumulator value and carry: load beats enable, and a load never produces a wrap.
    always_comb begin
        w_acc_next  = r_acc;
        w_wrap_next = 1'b0;
        if (load) begin
            w_acc_next  = w_load_acc;
            w_wrap_next = 1'b0;
        end else if (enable) begin
            {w_wrap_next, w_acc_next} = w_sum;
        end else begin
            w_acc_next  = r_acc;
            w_wrap_next = 1'b0;
        end
    end

    // Accumulator, wrap pulse and the pattern decoded from the next value so phases lands with acc.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc    <= '0;
            r_wrap   <= 1'b0;
            r_phases <= 16'h5555;
        end else begin
            r_acc    <= w_acc_next;
            r_wrap   <= w_wrap_next;
            r_phases <= ring_decode(w_acc_next[ACC_BITS-1 -: 5]);
        end
    end

`ifdef VCO_PHASE_WRAP_CNT_EN
    logic [WRAP_CNT_BITS-1:0] r_wrap_count;

    // Completed-period counter; loads leave it alone because w_wrap_next is low on a load.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wrap_count <= '0;
        end else if (w_wrap_next) begin
            r_wrap_count <= r_wrap_count + {{(WRAP_CNT_BITS-1){1'b0}}, 1'b1};
        end else begin
            r_wrap_count <= r_wrap_count;
        end
    end

    assign wrap_count = r_wrap_count;
`endif

    assign phases    = r_phases;
    assign phase_idx = r_acc[ACC_BITS-1 -: 5];
    assign wrap      = r_wrap;

endmodule

// File: tb/tb_vco_phase_gen.sv
// Directed bench for vco_phase_gen with ACC_BITS=8, FCW_BITS=8, WRAP_CNT_BITS=2.
module tb_vco_phase_gen;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [7:0] fcw;
    logic       load;
    logic [4:0] load_phase;
    logic [15:0] phases;
    logic [4:0] phase_idx;
    logic       wrap;
`ifdef VCO_PHASE_WRAP_CNT_EN
    logic [1:0] wrap_count;
`endif

    int n_checks;
    int n_fail;

    vco_phase_gen #(.ACC_BITS(8), .FCW_BITS(8), .WRAP_CNT_BITS(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .fcw        (fcw),
        .load       (load),
        .load_phase (load_phase),
        .phases     (phases),
        .phase_idx  (phase_idx),
        .wrap       (wrap)
`ifdef VCO_PHASE_WRAP_CNT_EN
        ,
        .wrap_count (wrap_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        #2;
        reset = 1'b1;
    endtask

    initial begin
        logic [15:0] exp_ph;
        logic [15:0] prev_ph;
        logic [4:0]  prev_idx;
        logic [4:0]  k;
        logic [4:0]  step;
        int          wraps;
        int          skips;
        logic [1:0]  exp_cnt;

        n_checks   = 0;
        n_fail     = 0;
        reset      = 1'b0;
        enable     = 1'b0;
        fcw        = 8'h00;
        load       = 1'b0;
        load_phase = 5'd0;

        // Reset state
        tick();
        check_eq("rst_phases", 32'(phases), 32'h5555);
        check_eq("rst_idx", 32'(phase_idx), 32'd0);
        check_eq("rst_wrap", 32'(wrap), 32'd0);
        reset = 1'b1;

        // Reset asserted mid-run takes effect at once and holds
        enable = 1'b1;
        fcw    = 8'h2C;
        tick(); tick(); tick();
        check_eq("run_idx", 32'(phase_idx), 32'd16);
        reset = 1'b0;
        #1;
        check_eq("midrst_phases", 32'(phases), 32'h5555);
        check_eq("midrst_idx", 32'(phase_idx), 32'd0);
        check_eq("midrst_wrap", 32'(wrap), 32'd0);
        tick();
        check_eq("rsthold_idx", 32'(phase_idx), 32'd0);
        check_eq("rsthold_phases", 32'(phases), 32'h5555);
        enable = 1'b0;
        reset  = 1'b1;
        tick();
        check_eq("post_rst_idx", 32'(phase_idx), 32'd0);

        // Full sweep at one index per clock, expected pattern built by single-bit toggles
        fcw     = 8'd8;
        enable  = 1'b1;
        exp_ph  = 16'h5555;
        prev_ph = phases;
        for (int i = 1; i <= 32; i++) begin
            tick();
            k = 5'(i);
            if ((i >= 1) && (i <= 16)) exp_ph[16 - i] = ~exp_ph[16 - i];
            else                       exp_ph[32 - i] = ~exp_ph[32 - i];
            check_eq("sweep_idx", 32'(phase_idx), 32'(k));
            check_eq("sweep_phases", 32'(phases), 32'(exp_ph));
            check_eq("sweep_onebit", 32'($countones(phases ^ prev_ph)), 32'd1);
            check_eq("sweep_wrap", 32'(wrap), (i == 32) ? 32'd1 : 32'd0);
            if (i == 1)  check_eq("k1_const", 32'(phases), 32'hD555);
            if (i == 2)  check_eq("k2_const", 32'(phases), 32'h9555);
            if (i == 16) check_eq("k16_const", 32'(phases), 32'hAAAA);
            if (i == 17) check_eq("k17_const", 32'(phases), 32'h2AAA);
            if (i == 31) check_eq("k31_const", 32'(phases), 32'h5554);
            prev_ph = phases;
        end

        // Fractional rate: 3 wraps in 256 clocks, no skipped index, acc back to 0
        enable = 1'b0;
        pulse_reset();
        fcw    = 8'd3;
        enable = 1'b1;
        wraps  = 0;
        skips  = 0;
        prev_idx = phase_idx;
        for (int i = 0; i < 256; i++) begin
            tick();
            if (wrap) wraps = wraps + 1;
            step = phase_idx - prev_idx;
            if (step > 5'd1) skips = skips + 1;
            prev_idx = phase_idx;
        end
        check_eq("frac_wraps", 32'(wraps), 32'd3);
        check_eq("frac_skips", 32'(skips), 32'd0);
        check_eq("frac_idx", 32'(phase_idx), 32'd0);
        fcw = 8'hFD;
        tick();
        check_eq("frac_acc0_idx", 32'(phase_idx), 32'd31);
        check_eq("frac_acc0_wrap", 32'(wrap), 32'd0);

        // Load priority over enable, from acc=8'hF8 where an add would carry
        enable     = 1'b0;
        load       = 1'b1;
        load_phase = 5'd31;
        tick();
        check_eq("load31_idx", 32'(phase_idx), 32'd31);
        fcw        = 8'd8;
        enable     = 1'b1;
        load_phase = 5'd5;
        tick();
        check_eq("ldpri_idx", 32'(phase_idx), 32'd5);
        check_eq("ldpri_wrap", 32'(wrap), 32'd0);
        check_eq("ldpri_phases", 32'(phases), 32'hAD55);
        load = 1'b0;
        tick();
        check_eq("ldnext_idx", 32'(phase_idx), 32'd6);
        check_eq("ldnext_phases", 32'(phases), 32'hA955);
        enable = 1'b0;
        tick();
        check_eq("hold_idx", 32'(phase_idx), 32'd6);
        check_eq("hold_wrap", 32'(wrap), 32'd0);
        fcw    = 8'd0;
        enable = 1'b1;
        tick();
        check_eq("fcw0_idx", 32'(phase_idx), 32'd6);
        check_eq("fcw0_wrap", 32'(wrap), 32'd0);

        // Half-period steps: wrap every second clock; counter (if built) mod 4
        enable = 1'b0;
        pulse_reset();
`ifdef VCO_PHASE_WRAP_CNT_EN
        check_eq("cnt_rst", 32'(wrap_count), 32'd0);
`endif
        fcw     = 8'h80;
        enable  = 1'b1;
        exp_cnt = 2'd0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if ((i % 2) == 0) exp_cnt = exp_cnt + 2'd1;
            check_eq("half_wrap", 32'(wrap), ((i % 2) == 0) ? 32'd1 : 32'd0);
            check_eq("half_idx", 32'(phase_idx), ((i % 2) == 0) ? 32'd0 : 32'd16);
`ifdef VCO_PHASE_WRAP_CNT_EN
            check_eq("cnt_seq", 32'(wrap_count), 32'(exp_cnt));
`endif
        end
        load       = 1'b1;
        load_phase = 5'd16;
        tick();
        check_eq("half_load_wrap", 32'(wrap), 32'd0);
        check_eq("half_load_idx", 32'(phase_idx), 32'd16);
`ifdef VCO_PHASE_WRAP_CNT_EN
        check_eq("cnt_load_hold", 32'(wrap_count), 32'd1);
`endif
        load = 1'b0;
        tick();
        check_eq("half_after_wrap", 32'(wrap), 32'd1);
`ifdef VCO_PHASE_WRAP_CNT_EN
        check_eq("cnt_after_load", 32'(wrap_count), 32'd2);
`endif
        tick();
        check_eq("wrap_pulse_len", 32'(wrap), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
